// File: rtl/cam_dvp_pkg.sv
// cam_dvp_pkg: shared types and helpers for the DVP capture front-end.
// Holds the capture FSM state enum, RGB565 layout and gray8_to_rgb565.
package cam_dvp_pkg;

  typedef enum logic [1:0] {
    ST_SKIP,
    ST_WAIT_VS,
    ST_ACTIVE
  } cap_state_e;

  localparam int R_W   = 5;
  localparam int G_W   = 6;
  localparam int B_W   = 5;
  localparam int R_OFF = 11;
  localparam int G_OFF = 5;
  localparam int B_OFF = 0;

  // Replicate the top bits of a gray byte into each RGB565 field.
  function automatic logic [15:0] gray8_to_rgb565(
    input logic [7:0] p
  );
    logic [15:0] px;
    px = '0;
    px[R_OFF +: R_W] = p[7 -: R_W];
    px[G_OFF +: G_W] = p[7 -: G_W];
    px[B_OFF +: B_W] = p[7 -: B_W];
    return px;
  endfunction

endpackage

// File: rtl/cam_dvp_capture_packer.sv
// cam_byte_packer: pairs HREF-run bytes into RGB565 words (or passes RAW).
// Ports: I_clk, I_rst, I_clr (abandon run), I_raw, I_href, I_byte in;
//        O_stb/O_data (pixel ready), O_line_end, O_odd (dangling byte) out.
module cam_byte_packer
  import cam_dvp_pkg::*;
(
  input  logic        I_clk,
  input  logic        I_rst,
  input  logic        I_clr,
  input  logic        I_raw,
  input  logic        I_href,
  input  logic [7:0]  I_byte,
  output logic        O_stb,
  output logic [15:0] O_data,
  output logic        O_line_end,
  output logic        O_odd
);

  logic       phase;
  logic       href_d;
  logic [7:0] hi;

  always_ff @(posedge I_clk) begin
    if (I_rst || I_clr) begin
      phase  <= 1'b0;
      href_d <= 1'b0;
      hi     <= '0;
    end else begin
      href_d <= I_href;
      if (I_href && !I_raw) begin
        phase <= ~phase;
        if (!phase) hi <= I_byte;
      end else if (!I_href) begin
        phase <= 1'b0;
      end
    end
  end

  // Strobes are combinational; the top registers them into O_de.
  assign O_stb      = I_href & ~I_clr & (I_raw | phase);
  assign O_data     = I_raw ? gray8_to_rgb565(I_byte)
                            : {hi, I_byte};
  assign O_line_end = href_d & ~I_href & ~I_clr;
  assign O_odd      = O_line_end & phase & ~I_raw;

endmodule

// File: rtl/cam_dvp_capture.sv
// cam_dvp_capture: DVP camera capture, start-up frame skip and crop.
// Ports: I_clk, I_rst, I_vsync, I_href, I_pixdata[7:0] (+I_raw_sel when
// CAM_DVP_RAW_GRAY_EN is defined); O_vs_n, O_de, O_data[15:0],
// O_frame_cnt[15:0], O_line_err, O_busy.
module cam_dvp_capture
  import cam_dvp_pkg::*;
#(
  parameter int H_RES       = 640,
  parameter int V_RES       = 480,
  parameter int SKIP_FRAMES = 2,
  parameter bit VS_POL      = 1'b1
) (
  input  logic        I_clk,
  input  logic        I_rst,
  input  logic        I_vsync,
  input  logic        I_href,
  input  logic [7:0]  I_pixdata,
`ifdef CAM_DVP_RAW_GRAY_EN
  input  logic        I_raw_sel,
`endif
  output logic        O_vs_n,
  output logic        O_de,
  output logic [15:0] O_data,
  output logic [15:0] O_frame_cnt,
  output logic        O_line_err,
  output logic        O_busy
);

  localparam int PW = $clog2(H_RES + 1);
  localparam int LW = $clog2(V_RES + 1);
  localparam logic [PW-1:0] H_MAX = PW'(H_RES);
  localparam logic [LW-1:0] V_MAX = LW'(V_RES);

  logic       vs_s0;
  logic       vs_q;
  logic       href_s0;
  logic [7:0] pix_s0;

  always_ff @(posedge I_clk) begin
    if (I_rst) begin
      vs_s0   <= 1'b0;
      vs_q    <= 1'b0;
      href_s0 <= 1'b0;
      pix_s0  <= '0;
    end else begin
      vs_s0   <= (I_vsync == VS_POL);
      vs_q    <= vs_s0;
      href_s0 <= I_href;
      pix_s0  <= I_pixdata;
    end
  end

  logic vs_rise;
  logic vs_fall;
  assign vs_rise = vs_s0 & ~vs_q;
  assign vs_fall = ~vs_s0 & vs_q;

  cap_state_e    state;
  logic [3:0]    skip_cnt;
  logic [PW-1:0] pix_cnt;
  logic [LW-1:0] line_cnt;
  logic          raw_mode;
  logic          raw_sel;

`ifdef CAM_DVP_RAW_GRAY_EN
  assign raw_sel = I_raw_sel;
`else
  assign raw_sel = 1'b0;
`endif

  logic        clr;
  logic        in_win;
  logic        pk_stb;
  logic        pk_line_end;
  logic        pk_odd;
  logic [15:0] pk_data;

  // HREF is ignored during sync and outside ACTIVE.
  assign clr    = (state != ST_ACTIVE) | vs_s0;
  assign in_win = (pix_cnt < H_MAX) && (line_cnt < V_MAX);

  cam_byte_packer u_packer (
    .I_clk      (I_clk),
    .I_rst      (I_rst),
    .I_clr      (clr),
    .I_raw      (raw_mode),
    .I_href     (href_s0),
    .I_byte     (pix_s0),
    .O_stb      (pk_stb),
    .O_data     (pk_data),
    .O_line_end (pk_line_end),
    .O_odd      (pk_odd)
  );

  always_ff @(posedge I_clk) begin
    if (I_rst) begin
      state       <= ST_SKIP;
      skip_cnt    <= 4'(SKIP_FRAMES);
      pix_cnt     <= '0;
      line_cnt    <= '0;
      raw_mode    <= 1'b0;
      O_vs_n      <= 1'b1;
      O_de        <= 1'b0;
      O_data      <= '0;
      O_frame_cnt <= '0;
      O_line_err  <= 1'b0;
      O_busy      <= 1'b0;
    end else begin
      O_vs_n <= ~vs_s0;
      O_de   <= pk_stb & in_win;
      if (pk_stb && in_win) O_data <= pk_data;
      if (pk_stb && pix_cnt != H_MAX)
        pix_cnt <= pix_cnt + 1'b1;
      if (pk_line_end) begin
        pix_cnt <= '0;
        if (line_cnt != V_MAX)
          line_cnt <= line_cnt + 1'b1;
        if (pk_odd || pix_cnt < H_MAX)
          O_line_err <= 1'b1;
      end
      unique case (state)
        ST_SKIP: begin
          if (skip_cnt == 4'd0) begin
            state <= ST_WAIT_VS;
          end else if (vs_fall) begin
            skip_cnt <= skip_cnt - 4'd1;
            if (skip_cnt == 4'd1)
              state <= ST_WAIT_VS;
          end
        end
        ST_WAIT_VS: begin
          raw_mode <= raw_sel;
          if (vs_fall) begin
            state    <= ST_ACTIVE;
            O_busy   <= 1'b1;
            pix_cnt  <= '0;
            line_cnt <= '0;
          end
        end
        ST_ACTIVE: begin
          // Short frames still count; a partial line is dropped.
          if (vs_rise) begin
            state       <= ST_WAIT_VS;
            O_busy      <= 1'b0;
            O_frame_cnt <= O_frame_cnt + 16'd1;
          end
        end
        default: state <= ST_SKIP;
      endcase
    end
  end

endmodule

// File: doc/cam_dvp_capture.md
Name: cam_dvp_capture

Overview:
- Capture front-end for the DVP camera port (VSYNC/HREF/PIXDATA, sampled on the pixel clock).
- Packs byte pairs into RGB565 pixels and crops each frame to a fixed window.
- Discards start-up frames and flags malformed lines.
- Drives the frame-buffer write channel (vs_n/de/data16) directly upstream of the video frame buffer.

Parameters:
H_RES, 640, pixels per line passed downstream; extra pixels dropped
V_RES, 480, lines per frame passed downstream; extra lines dropped
SKIP_FRAMES, 2, whole frames suppressed after reset (0..15)
VS_POL, 1, active level of I_vsync (1 = high during sync)

Ports:
I_clk  in  1  camera pixel clock (PIXCLK); all logic on rising edge
I_rst  in  1  synchronous reset, active high
I_vsync  in  1  camera VSYNC
I_href  in  1  camera HREF, high during line byte stream
I_pixdata  in  8  camera data byte (upper 8 of the 10-bit bus)
O_vs_n  out  1  frame sync to frame buffer, low during sync
O_de  out  1  pixel valid, one cycle per pixel
O_data  out  16  RGB565 pixel {R5,G6,B5}
O_frame_cnt  out  16  frames delivered downstream, wraps 0xFFFF->0
O_line_err  out  1  sticky: odd byte count or short line seen
O_busy  out  1  high while in ACTIVE state

Behaviour:
- Reset: O_vs_n=1, O_de=0, O_data=0, O_frame_cnt=0, O_line_err=0, O_busy=0, skip counter=SKIP_FRAMES, FSM=SKIP.
- Inputs registered once (stage 0). All outputs registered. Latency: input edge -> output = 2 cycles.
- vs_act = (I_vsync == VS_POL). O_vs_n = ~vs_act, 2-cycle delay. Passed in every state, including SKIP.
- FSM states:
  - SKIP: de suppressed. Each vs_act falling edge decrements the skip counter. At 0 -> WAIT_VS. SKIP_FRAMES=0 -> WAIT_VS directly after reset.
  - WAIT_VS: vs_act falling edge -> ACTIVE; clear line/pixel counters.
  - ACTIVE: capture. vs_act rising edge -> WAIT_VS and O_frame_cnt+1. A frame is counted even if it is short.
- Byte pairing, per HREF-high run:
  - Even byte index = high byte; odd byte index = low byte.
  - O_de=1 for one cycle on the cycle after the low byte is captured. O_de is never asserted on two consecutive cycles.
  - HREF falling with a dangling high byte: byte discarded, O_line_err set.
- Cropping:
  - Pixel counter 0..H_RES-1; pixels with count >= H_RES are not emitted.
  - Line counter increments on HREF falling edge. Lines with count >= V_RES are not emitted.
  - Line ending with fewer than H_RES pixels sets O_line_err; no padding.
- Boundaries:
  - HREF high while vs_act: ignored.
  - vs_act rising mid-line: line abandoned, no error, frame closed.
  - Reset mid-frame: outputs return to reset values on the next edge; skipping restarts.
- O_line_err clears only on reset.
- Counter widths: pixel and line counters use $clog2(H_RES+1) and $clog2(V_RES+1) bits and saturate at max.

Optional Feature:
- Macro CAM_DVP_RAW_GRAY_EN.
- Defined:
  - Adds input I_raw_sel (1 bit). When I_raw_sel=1, each byte is one RAW pixel: O_de every byte, O_data={p[7:3],p[7:2],p[7:3]}, H_RES counts bytes, no pairing error.
  - I_raw_sel is sampled only in WAIT_VS; mid-frame changes take effect next frame.
- Undefined: port absent; RGB565 pairing only.

Decomposition:
- Package cam_dvp_pkg:
  - FSM state enum {SKIP, WAIT_VS, ACTIVE}.
  - RGB565 field widths/offsets.
  - Function gray8_to_rgb565.
- Sub-module cam_byte_packer: HREF-run byte pairing, de strobe, odd-byte detect. The FSM and crop counters stay in the top.

Test Plan:
- Reset, SKIP_FRAMES=2, three 640x480 frames of pattern bytes -> O_de never asserted in frames 1-2; frame 3 gives exactly 307200 de pulses; O_frame_cnt=1 after frame 3 vsync rises.
- Bytes 0xF8,0x1F on first pair -> O_data=16'hF81F exactly 2 cycles after the 0x1F byte is applied; O_de high 1 cycle.
- Line of 1283 bytes (641.5 pixels) -> 640 pixels emitted, O_line_err=1 from HREF fall.
- Frame of 500 lines x 640 px -> exactly 480 lines emitted; O_frame_cnt increments by 1.
- Assert I_rst mid-line of frame 3 -> next edge O_de=0, O_vs_n=1, O_frame_cnt=0; next two frames suppressed again.
- With CAM_DVP_RAW_GRAY_EN and I_raw_sel=1, byte 0x80 -> O_data=16'h8410, one de per byte, 640 de per line.
